stream_demux_1x2: RTL

- 1:2 packet demultiplexer. It is the distribution-side counterpart of the 2:1 selector.
- Accepts one valid/ready stream and steers whole packets to output 0 or output 1, chosen by a select bit sampled on the first beat of each packet.
- Each output has a one-entry registered stage, giving 1-cycle latency and full throughput.
- Sits between a shared producer and two independent consumers.

---
 rtl/stream_demux_1x2.sv | 120 ++++++++++++
 1 files changed

// File: rtl/stream_demux_1x2.sv
// 1:2 packet demultiplexer: steers whole valid/ready packets to one of two
// outputs, each behind a one-entry registered stage.
//
// state | meaning
// IDLE  | next accepted beat is a first beat; destination taken from in_sel
// ROUTE | multi-beat packet in progress; destination locked in route_q
module stream_demux_1x2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  output logic             out0_last,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  output logic             out1_last,
  input  logic             out1_ready,
  output logic             busy
);

  typedef enum logic {IDLE, ROUTE} state_e;

  state_e           state_q, state_d;
  logic             route_q, route_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             valid0_q, valid0_d, valid1_q, valid1_d;
  logic             last0_q, last0_d, last1_q, last1_d;

  logic target, rdy0, rdy1, accept, load0, load1;

  // A stage can take a beat when empty or when it is being drained this cycle.
  always_comb begin
    target   = (state_q == ROUTE) ? route_q : in_sel;
    rdy0     = !valid0_q || out0_ready;
    rdy1     = !valid1_q || out1_ready;
    in_ready = target ? rdy1 : rdy0;
    accept   = in_valid && in_ready;
    load0    = accept && !target;
    load1    = accept && target;
  end

  always_comb begin
    valid0_d = valid0_q;
    data0_d  = data0_q;
    last0_d  = last0_q;
    if (load0) begin
      valid0_d = 1'b1;
      data0_d  = in_data;
      last0_d  = in_last;
    end else if (out0_ready) begin
      valid0_d = 1'b0;
    end

    valid1_d = valid1_q;
    data1_d  = data1_q;
    last1_d  = last1_q;
    if (load1) begin
      valid1_d = 1'b1;
      data1_d  = in_data;
      last1_d  = in_last;
    end else if (out1_ready) begin
      valid1_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = ROUTE;
          route_d = in_sel;
        end
      end
      ROUTE: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      route_q  <= 1'b0;
      valid0_q <= 1'b0;
      data0_q  <= '0;
      last0_q  <= 1'b0;
      valid1_q <= 1'b0;
      data1_q  <= '0;
      last1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      route_q  <= route_d;
      valid0_q <= valid0_d;
      data0_q  <= data0_d;
      last0_q  <= last0_d;
      valid1_q <= valid1_d;
      data1_q  <= data1_d;
      last1_q  <= last1_d;
    end
  end

  assign out0_data  = data0_q;
  assign out0_valid = valid0_q;
  assign out0_last  = last0_q;
  assign out1_data  = data1_q;
  assign out1_valid = valid1_q;
  assign out1_last  = last1_q;
  assign busy       = (state_q == ROUTE);

endmodule
